uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single UART TX FIFO between NREQ independent byte-stream requesters, such as the command responder, the debug printer and the status reporter. Grants are round-robin at packet granularity. Once a requester is granted, its bytes are written into the FIFO without interleaving until it marks the last byte. The block sits directly in front of the TX FIFO write port; the FIFO's full flag provides backpressure.

Parameters:
NREQ, 4, number of requesters (2..8)
WORD, 8, data width; must equal the TX FIFO WORD
MAX_BURST, 16, maximum bytes per grant when the burst limit is compiled in (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset: synchronous, active-high
req_valid  in  NREQ  requester i has a byte on its data lane
req_data  in  NREQ*WORD  lane i occupies bits [i*WORD +: WORD]
req_last  in  NREQ  the current byte of requester i ends its packet
req_ready  out  NREQ  one-hot or zero; byte of requester i accepted this cycle
fifo_wr  out  1  TX FIFO write strobe
fifo_wr_data  out  WORD  TX FIFO write data
fifo_full  in  1  TX FIFO full flag (registered in the FIFO)
grant_id  out  $clog2(NREQ)  index of the current or last grantee
busy  out  1  high while in XFER

Behaviour:
- Reset (on a clk edge with rst=1):
  - state=IDLE, rr_ptr=NREQ-1, grant_id=0, burst_cnt=0.
  - req_ready=0, fifo_wr=0, busy=0; fifo_wr_data is don't-care (drive 0).
  - Reset mid-packet abandons the packet. Nothing partial is retried; the requester must resend.
- State IDLE:
  - If any req_valid=1, select the first asserted index searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - Register the selection into grant_id, go to XFER, clear burst_cnt.
  - No bytes move in IDLE. The arbitration gap is exactly 1 cycle per packet.
- State XFER, with g=grant_id:
  - Accept condition: acc = req_valid[g] & ~fifo_full.
  - req_ready[g]=acc; all other req_ready bits=0.
  - fifo_wr=acc; fifo_wr_data=req_data lane g. Both are combinational, so the write happens in the same cycle as the handshake.
  - req_valid[g]=0 mid-packet: stay in XFER, write nothing. The grant is held and other requesters wait.
  - fifo_full=1: no write, req_ready=0. The requester must hold its data stable.
  - acc & req_last[g]: set rr_ptr=g, go to IDLE.
  - Each acc increments burst_cnt; its width is 8 bits and it saturates.
- Round-robin fairness: with all NREQ requesters continuously valid, grants cycle 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 packets.
- grant_id holds its value in IDLE. busy=1 exactly while the state is XFER.
- fifo_wr is never asserted while fifo_full=1. This is required because the FIFO's simultaneous read/write path does not check full.

Optional Feature:
UART_TX_ARB_BURST_LIMIT_EN
- Defined: in XFER, an acc that brings burst_cnt to MAX_BURST without req_last also releases the grant.
  - Set rr_ptr=g, go to IDLE.
  - The packet continues on a later grant of the same requester.
  - This bounds the latency seen by other requesters to MAX_BURST+1 cycles per foreign grant, excluding fifo_full stalls.
- Undefined: the grant is released only on req_last. burst_cnt is still maintained for debug.

Test Plan:
1. Reset with only req 2 valid, sending 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3) -> grant_id=2 after 1 cycle; fifo_wr high for 3 consecutive cycles with that data; busy falls the cycle after 0xA3.
2. Reqs 0,1,3 each continuously valid with 2-byte packets -> FIFO order 0,0,1,1,3,3,0,0…; exactly 1 idle cycle between packets; req 2 never granted.
3. fifo_full held high for 5 cycles in the middle of a 4-byte packet from req 1 -> fifo_wr=0 and req_ready=0 during the stall; bytes resume in order with none lost or duplicated.
4. Req 0 granted and drops req_valid for 3 cycles mid-packet while req 1 is valid -> grant is held on 0; req 1 gets no req_ready until req 0 sends last.
5. rst asserted during the 2nd byte of a 4-byte packet -> next cycle state=IDLE, all outputs 0; the following arbitration grants requester 0 first.
6. With UART_TX_ARB_BURST_LIMIT_EN and MAX_BURST=4: req 0 sends a 10-byte packet while req 1 sends 1-byte packets -> FIFO sequence is 4×r0, r1, 4×r0, r1, 2×r0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte lanes plus the TX FIFO write port seen by uart_tx_arbiter.
// The arbiter uses the slave modport; requesters and the FIFO sit on the master side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int WORD = 8
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*WORD-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_wr;
    logic [WORD-1:0]      fifo_wr_data;
    logic                 fifo_full;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr, fifo_wr_data
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr, fifo_wr_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the shared UART TX FIFO write port.
// Optional burst limit: define UART_TX_ARB_BURST_LIMIT_EN to release a grant after MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int WORD      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    uart_tx_arbiter_if.slave        bus,
    output logic [$clog2(NREQ)-1:0] grant_id_o,
    output logic                    busy_o
);
    localparam int GW = $clog2(NREQ);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

`ifdef UART_TX_ARB_BURST_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [7:0]    burst_cnt_q, burst_cnt_d;
    logic          acc_s;
    logic          limit_hit_s;

    // First valid requester after ptr, wrapping modulo NREQ; ptr itself is checked last.
    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] ptr, input logic [NREQ-1:0] valid);
        logic [GW-1:0] sel;
        logic [GW-1:0] idx;
        logic          found;
        sel   = {GW{1'b0}};
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = GW'((int'(ptr) + i) % NREQ);
            if (!found && valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign limit_hit_s = LIMIT_EN && (burst_cnt_q == BURST_LAST);

    // State register and arbitration bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= GW'(NREQ - 1);
            grant_id_q  <= {GW{1'b0}};
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next state plus the same-cycle handshake and FIFO write.
    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        grant_id_d        = grant_id_q;
        burst_cnt_d       = burst_cnt_q;
        acc_s             = 1'b0;
        bus.req_ready     = {NREQ{1'b0}};
        bus.fifo_wr       = 1'b0;
        bus.fifo_wr_data  = {WORD{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    grant_id_d  = rr_pick(rr_ptr_q, bus.req_valid);
                    burst_cnt_d = 8'd0;
                    state_d     = ST_XFER;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_XFER: begin
                // Never write while full: the FIFO's bypass path does not check it.
                acc_s            = bus.req_valid[grant_id_q] & ~bus.fifo_full;
                bus.fifo_wr_data = bus.req_data[grant_id_q*WORD +: WORD];
                if (acc_s) begin
                    bus.req_ready[grant_id_q] = 1'b1;
                    bus.fifo_wr               = 1'b1;
                    if (burst_cnt_q == 8'hFF) begin
                        burst_cnt_d = burst_cnt_q;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                    if (bus.req_last[grant_id_q] || limit_hit_s) begin
                        rr_ptr_d = grant_id_q;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_XFER;
                    end
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_id_o = grant_id_q;
    assign busy_o     = (state_q == ST_XFER);
endmodule
